// File: rtl/pcp_imem_loader_pkg.sv
// Shared coprocessor constants: imem geometry, stream word width and
// the loader state encoding.
package pcp_imem_loader_pkg;

    localparam int PCP_IMEM_ADDR_W = 10;
    localparam int PCP_IMEM_DATA_W = 75;
    localparam int PCP_WORD_W      = 32;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_WRITE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/pcp_imem_loader.sv
// Packs three 32-bit stream words into one 75-bit instruction and writes it
// to consecutive imem addresses through the imem write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LD_IDLE  | waiting for start; counters and outputs hold
// LD_FILL  | s_ready=1, collecting words 0..2 of the current instruction
// LD_WRITE | imem_we_2 pulse; advance address, decrement remaining count
module pcp_imem_loader
    import pcp_imem_loader_pkg::*;
#(
    parameter int ADDR_W  = PCP_IMEM_ADDR_W,
    parameter int INSTR_W = PCP_IMEM_DATA_W,
    parameter int WORD_W  = PCP_WORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    instr_count,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [ADDR_W-1:0]  imem_addr_2,
    output logic [INSTR_W-1:0] imem_in_2,
    output logic               imem_we_2,
    output logic               busy,
    output logic               done,
    output logic               fmt_err
);

    localparam int HI_W  = INSTR_W - 2 * WORD_W;
    localparam int ASM_W = 2 * WORD_W;

    ld_state_e          state_q, state_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    rem_q, rem_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               fmt_q, fmt_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        fmt_d   = fmt_q;

        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    fmt_d  = 1'b0;
                    if (instr_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LD_FILL;
                        wcnt_d  = 2'd0;
                        asm_d   = '0;
                        addr_d  = base_addr;
                        rem_d   = instr_count;
                    end
                end
            end
            LD_FILL: begin
                if (s_valid) begin
                    case (wcnt_q)
                        2'd0: begin
                            asm_d[WORD_W-1:0] = s_data;
                            wcnt_d            = 2'd1;
                        end
                        2'd1: begin
                            asm_d[ASM_W-1:WORD_W] = s_data;
                            wcnt_d                = 2'd2;
                        end
                        default: begin
                            // Output registers load here so the write pulse lands in LD_WRITE.
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = {s_data[HI_W-1:0], asm_q};
                            if (|s_data[WORD_W-1:HI_W]) fmt_d = 1'b1;
                            wcnt_d  = 2'd0;
                            state_d = LD_WRITE;
                        end
                    endcase
                end
            end
            LD_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - (ADDR_W + 1)'(1);
                if (rem_q == (ADDR_W + 1)'(1)) begin
                    state_d = LD_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LD_FILL;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LD_IDLE;
            wcnt_q  <= 2'd0;
            asm_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            fmt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            fmt_q   <= fmt_d;
        end
    end

    assign s_ready     = (state_q == LD_FILL);
    assign busy        = (state_q != LD_IDLE);
    assign imem_we_2   = we_q;
    assign imem_addr_2 = waddr_q;
    assign imem_in_2   = wdata_q;
    assign done        = done_q;
    assign fmt_err     = fmt_q;

endmodule
